// File: rtl/riscv_pipe_pkg.sv
// Shared types for the RV32I pipeline: hazard FSM states, forwarding selects and the
// operand forwarding decision used when an instruction is decoded.
package riscv_pipe_pkg;

  localparam int unsigned REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FREEZE = 2'd1,
    HALT   = 2'd2
  } hz_state_e;

  typedef enum logic [1:0] {
    FWD_REG   = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_e;

  // The younger producer (EX) wins over MEM; x0 never forwards.
  function automatic fwd_sel_e fwd_select(
    input logic                  uses,
    input logic [REG_ADDR_W-1:0] rs,
    input logic [REG_ADDR_W-1:0] ex_rd,
    input logic                  ex_reg_write,
    input logic [REG_ADDR_W-1:0] mem_rd,
    input logic                  mem_reg_write
  );
    fwd_sel_e sel;
    sel = FWD_REG;
    if (uses) begin
      if (ex_reg_write && (ex_rd != '0) && (rs == ex_rd)) begin
        sel = FWD_EXMEM;
      end else if (mem_reg_write && (mem_rd != '0) && (rs == mem_rd)) begin
        sel = FWD_MEMWB;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_perf_cnt.sv
// Hazard performance counters (load-use stalls, branch flushes, freeze cycles).
// Instantiated by pipeline_hazard_ctrl only when HAZARD_PERF_EN is defined.
module hazard_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_stall,
  input  logic        i_flush,
  input  logic        i_freeze,
  output logic [31:0] o_stall_cnt,
  output logic [31:0] o_flush_cnt,
  output logic [31:0] o_freeze_cnt
);

  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;
  logic [31:0] r_freeze_cnt;

  // Counters wrap naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt  <= '0;
      r_flush_cnt  <= '0;
      r_freeze_cnt <= '0;
    end else begin
      if (i_stall)  r_stall_cnt  <= r_stall_cnt + 32'd1;
      if (i_flush)  r_flush_cnt  <= r_flush_cnt + 32'd1;
      if (i_freeze) r_freeze_cnt <= r_freeze_cnt + 32'd1;
    end
  end

  assign o_stall_cnt  = r_stall_cnt;
  assign o_flush_cnt  = r_flush_cnt;
  assign o_freeze_cnt = r_freeze_cnt;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the five-stage pipeline: stall/flush/freeze control,
// registered EX forwarding selects and a dmem timeout halt. Counters need HAZARD_PERF_EN.
module pipeline_hazard_ctrl
  import riscv_pipe_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_reg_write,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_reg_write,
  input  logic                  ex_branch_taken,
  input  logic                  dmem_busy,
  output logic                  pc_en,
  output logic                  if_id_en,
  output logic                  id_ex_en,
  output logic                  ex_mem_en,
  output logic                  mem_wb_en,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic                  mem_timeout,
  output logic [1:0]            state,
  output logic [31:0]           stall_cnt,
  output logic [31:0]           flush_cnt,
  output logic [31:0]           freeze_cnt
);

  localparam logic [1:0] ST_RUN    = RUN;
  localparam logic [1:0] ST_FREEZE = FREEZE;
  localparam logic [1:0] ST_HALT   = HALT;

  logic [1:0]  r_state;
  logic [1:0]  w_state_d;
  logic [15:0] r_wait_cnt;
  logic        r_mem_timeout;
  logic [1:0]  r_fwd_a;
  logic [1:0]  r_fwd_b;
  logic [1:0]  w_fwd_a_d;
  logic [1:0]  w_fwd_b_d;
  logic        w_load_use;
  logic        w_freeze;
  logic        w_last_busy;

  assign w_load_use = ex_mem_read && (ex_rd != '0) &&
                      ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                       (id_uses_rs2 && (id_rs2 == ex_rd)));

  assign w_freeze    = dmem_busy || (r_state == ST_HALT);
  // Busy in this cycle completes MAX_WAIT consecutive busy cycles.
  assign w_last_busy = dmem_busy && (r_wait_cnt == 16'(MAX_WAIT - 1));

  assign w_fwd_a_d = fwd_select(id_uses_rs1, id_rs1, ex_rd, ex_reg_write, mem_rd, mem_reg_write);
  assign w_fwd_b_d = fwd_select(id_uses_rs2, id_rs2, ex_rd, ex_reg_write, mem_rd, mem_reg_write);

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      ST_RUN: begin
        if (w_last_busy)    w_state_d = ST_HALT;
        else if (dmem_busy) w_state_d = ST_FREEZE;
      end
      ST_FREEZE: begin
        if (!dmem_busy)       w_state_d = ST_RUN;
        else if (w_last_busy) w_state_d = ST_HALT;
      end
      ST_HALT: w_state_d = ST_HALT;
      default: w_state_d = ST_RUN;
    endcase
  end

  always_comb begin
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    id_ex_en    = 1'b1;
    ex_mem_en   = 1'b1;
    mem_wb_en   = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    if (rst || w_freeze) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
      mem_wb_en = 1'b0;
    end else if (ex_branch_taken) begin
      // The ID instruction is on the wrong path, so any load-use on it is moot.
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (w_load_use) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_RUN;
      r_wait_cnt    <= '0;
      r_mem_timeout <= 1'b0;
      r_fwd_a       <= FWD_REG;
      r_fwd_b       <= FWD_REG;
    end else begin
      r_state <= w_state_d;
      if (!dmem_busy) begin
        r_wait_cnt <= '0;
      end else if (r_wait_cnt != 16'hFFFF) begin
        r_wait_cnt <= r_wait_cnt + 16'd1;
      end
      if (w_state_d == ST_HALT) r_mem_timeout <= 1'b1;
      if (id_ex_flush) begin
        r_fwd_a <= FWD_REG;
        r_fwd_b <= FWD_REG;
      end else if (id_ex_en) begin
        r_fwd_a <= w_fwd_a_d;
        r_fwd_b <= w_fwd_b_d;
      end
    end
  end

  assign state       = r_state;
  assign mem_timeout = r_mem_timeout;
  assign fwd_a_sel   = r_fwd_a;
  assign fwd_b_sel   = r_fwd_b;

`ifdef HAZARD_PERF_EN
  logic w_stall_evt;
  logic w_flush_evt;

  assign w_stall_evt = !w_freeze && !ex_branch_taken && w_load_use;
  assign w_flush_evt = !w_freeze && ex_branch_taken;

  hazard_perf_cnt u_perf (
    .clk          (clk),
    .rst          (rst),
    .i_stall      (w_stall_evt),
    .i_flush      (w_flush_evt),
    .i_freeze     (w_freeze),
    .o_stall_cnt  (stall_cnt),
    .o_flush_cnt  (flush_cnt),
    .o_freeze_cnt (freeze_cnt)
  );
`else
  assign stall_cnt  = '0;
  assign flush_cnt  = '0;
  assign freeze_cnt = '0;
`endif

endmodule
